// File: rtl/wb_slave_mux.sv
// rtl/wb_slave_mux.sv - Wishbone classic 1-master to N-slave router with decode/timeout errors
module wb_slave_mux #(
  parameter int NUM_SLAVES     = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_SLAVES-1:0]      input_select,
  input  logic [31:0]                m_adr_i,
  input  logic [31:0]                m_dat_i,
  input  logic [3:0]                 m_sel_i,
  input  logic                       m_we_i,
  input  logic                       m_cyc_i,
  input  logic                       m_stb_i,
  output logic [31:0]                m_dat_o,
  output logic                       m_ack_o,
  output logic                       m_err_o,
  output logic [31:0]                s_adr_o,
  output logic [31:0]                s_dat_o,
  output logic [3:0]                 s_sel_o,
  output logic                       s_we_o,
  output logic [NUM_SLAVES-1:0]      s_cyc_o,
  output logic [NUM_SLAVES-1:0]      s_stb_o,
  input  logic [NUM_SLAVES-1:0][31:0] s_dat_i,
  input  logic [NUM_SLAVES-1:0]      s_ack_i,
  input  logic [NUM_SLAVES-1:0]      s_err_i
);

  localparam int GW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ERR    = 2'd2
  } state_t;

  state_t         state_q;
  logic [GW-1:0]  grant_q;
  logic [TW-1:0]  tmo_q;

  logic           sel_seen;
  logic           sel_multi;
  logic [GW-1:0]  sel_idx;
  logic           sel_one_hot;

  // Shared request lines go to every slave untouched; only cyc/stb are steered
  assign s_adr_o = m_adr_i;
  assign s_dat_o = m_dat_i;
  assign s_sel_o = m_sel_i;
  assign s_we_o  = m_we_i;

  // Reduce the decoder's select vector to "exactly one hit" plus the index of that hit
  always_comb begin
    sel_seen  = 1'b0;
    sel_multi = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (input_select[i]) begin
        if (sel_seen) sel_multi = 1'b1;
        sel_seen = 1'b1;
        sel_idx  = GW'(i);
      end
    end
  end

  assign sel_one_hot = sel_seen & ~sel_multi;

  // Route strobes to the granted slave and its response back; ERR emits a lone error pulse
  always_comb begin
    s_cyc_o = '0;
    s_stb_o = '0;
    m_ack_o = 1'b0;
    m_err_o = 1'b0;
    m_dat_o = '0;
    if (state_q == ST_ACTIVE) begin
      s_cyc_o[grant_q] = m_cyc_i;
      s_stb_o[grant_q] = m_stb_i;
      // A master that has dropped cyc has abandoned the transfer and must see nothing
      m_ack_o = m_cyc_i & s_ack_i[grant_q];
      m_err_o = m_cyc_i & s_err_i[grant_q];
      m_dat_o = s_dat_i[grant_q];
    end else if (state_q == ST_ERR) begin
      m_err_o = 1'b1;
    end
  end

  // Transaction FSM: decode in IDLE, hold grant through ACTIVE, one-cycle ERR back to IDLE
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      tmo_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (m_cyc_i && m_stb_i) begin
            if (sel_one_hot) begin
              grant_q <= sel_idx;
              tmo_q   <= '0;
              state_q <= ST_ACTIVE;
            end else begin
              state_q <= ST_ERR;
            end
          end
        end
        ST_ACTIVE: begin
          if (!m_cyc_i) begin
            state_q <= ST_IDLE;
          end else if (s_ack_i[grant_q] || s_err_i[grant_q]) begin
            state_q <= ST_IDLE;
          end else if (tmo_q == TMO_LAST) begin
            state_q <= ST_ERR;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        ST_ERR:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_slave_mux.sv
// tb/tb_wb_slave_mux.sv - self-checking bench for wb_slave_mux (vectors, corner sequences, random vs model)
module tb_wb_slave_mux;

  localparam int NS  = 2;
  localparam int TMO = 4;

  logic            clk;
  logic            rst;
  logic [NS-1:0]   input_select;
  logic [31:0]     m_adr, m_dat_w;
  logic [3:0]      m_sel;
  logic            m_we, m_cyc, m_stb;
  logic [31:0]     m_dat_r;
  logic            m_ack, m_err;
  logic [31:0]     s_adr, s_dat_w;
  logic [3:0]      s_sel;
  logic            s_we;
  logic [NS-1:0]   s_cyc, s_stb;
  logic [NS-1:0][31:0] s_dat_r;
  logic [NS-1:0]   s_ack, s_err;

  int checks = 0;
  int errors = 0;

  wb_slave_mux #(.NUM_SLAVES(NS), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_i(rst), .input_select(input_select),
    .m_adr_i(m_adr), .m_dat_i(m_dat_w), .m_sel_i(m_sel), .m_we_i(m_we),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb),
    .m_dat_o(m_dat_r), .m_ack_o(m_ack), .m_err_o(m_err),
    .s_adr_o(s_adr), .s_dat_o(s_dat_w), .s_sel_o(s_sel), .s_we_o(s_we),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb),
    .s_dat_i(s_dat_r), .s_ack_i(s_ack), .s_err_i(s_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       cyc, stb, we;
    logic [1:0] sel, ack, err;
    logic [1:0] e_cyc, e_stb;
    logic       e_ack, e_err;
    logic [31:0] e_dat;
  } vec_t;

  vec_t vt[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic c, input logic s, input logic [1:0] sl,
                       input logic [1:0] a, input logic [1:0] e);
    rst = r; m_cyc = c; m_stb = s; input_select = sl; s_ack = a; s_err = e;
  endtask

  task automatic expect_out(input string nm, input logic [1:0] ecyc, input logic [1:0] estb,
                            input logic eack, input logic eerr, input logic [31:0] edat);
    #4;
    chk({nm, ".s_cyc"}, 32'(s_cyc), 32'(ecyc));
    chk({nm, ".s_stb"}, 32'(s_stb), 32'(estb));
    chk({nm, ".ack"},   32'(m_ack), 32'(eack));
    chk({nm, ".err"},   32'(m_err), 32'(eerr));
    chk({nm, ".dat"},   m_dat_r, edat);
  endtask

  localparam logic [31:0] D0 = 32'h1111_2222;
  localparam logic [31:0] D1 = 32'hCAFE_F00D;

  // reference model state: in a transfer with slave mg for mwait cycles, or owing an error pulse
  bit mbusy, merr;
  int mg, mwait;

  initial begin
    logic [1:0] e_cyc, e_stb;
    logic e_ack, e_err;
    logic [31:0] e_dat;
    int r;

    drive(1, 0, 0, 2'b00, 2'b00, 2'b00);
    m_adr = 32'h1000_0004; m_dat_w = 32'h0; m_sel = 4'hF; m_we = 1'b0;
    s_dat_r[0] = D0; s_dat_r[1] = D1;
    #1;
    tick(); tick();
    drive(0, 0, 0, 2'b00, 2'b00, 2'b00);
    expect_out("reset", 2'b00, 2'b00, 0, 0, 32'h0);
    tick();

    //        cyc stb we sel    ack    err    e_cyc  e_stb  ack err dat
    vt[0]  = '{1, 1, 0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 32'h0};
    vt[1]  = '{1, 1, 0, 2'b10, 2'b00, 2'b00, 2'b10, 2'b10, 0, 0, D1};
    vt[2]  = '{1, 1, 0, 2'b10, 2'b10, 2'b00, 2'b10, 2'b10, 1, 0, D1};
    vt[3]  = '{0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 32'h0};
    vt[4]  = '{1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 32'h0};
    vt[5]  = '{0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 32'h0};
    vt[6]  = '{0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 32'h0};
    vt[7]  = '{1, 1, 0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 32'h0};
    vt[8]  = '{0, 0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 32'h0};
    vt[9]  = '{0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 32'h0};
    vt[10] = '{1, 1, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 32'h0};
    vt[11] = '{1, 1, 0, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 0, 1, D0};
    vt[12] = '{0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 32'h0};
    vt[13] = '{1, 1, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 32'h0};
    vt[14] = '{1, 1, 1, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 1, 0, D0};
    vt[15] = '{1, 1, 0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 32'h0};
    vt[16] = '{1, 1, 0, 2'b10, 2'b10, 2'b00, 2'b10, 2'b10, 1, 0, D1};
    vt[17] = '{0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 32'h0};

    for (int i = 0; i < 18; i++) begin
      drive(0, vt[i].cyc, vt[i].stb, vt[i].sel, vt[i].ack, vt[i].err);
      m_we = vt[i].we;
      expect_out($sformatf("vec%0d", i), vt[i].e_cyc, vt[i].e_stb, vt[i].e_ack, vt[i].e_err, vt[i].e_dat);
      tick();
    end
    m_we = 1'b0;

    // timeout: slave0 never answers, four ACTIVE cycles then a single error cycle
    drive(0, 1, 1, 2'b01, 2'b00, 2'b00);
    expect_out("tmo.req", 2'b00, 2'b00, 0, 0, 32'h0);
    tick();
    for (int k = 1; k <= TMO; k++) begin
      expect_out($sformatf("tmo.wait%0d", k), 2'b01, 2'b01, 0, 0, D0);
      tick();
    end
    expect_out("tmo.err", 2'b00, 2'b00, 0, 1, 32'h0);
    tick();
    drive(0, 0, 0, 2'b00, 2'b00, 2'b00);
    expect_out("tmo.idle", 2'b00, 2'b00, 0, 0, 32'h0);
    tick();

    // abort: master drops cyc mid-transfer, strobes fall the same cycle, no response
    drive(0, 1, 1, 2'b10, 2'b00, 2'b00);
    tick();
    expect_out("abort.act", 2'b10, 2'b10, 0, 0, D1);
    tick();
    drive(0, 0, 0, 2'b10, 2'b00, 2'b00);
    expect_out("abort.drop", 2'b00, 2'b00, 0, 0, D1);
    tick();
    expect_out("abort.after", 2'b00, 2'b00, 0, 0, 32'h0);
    tick();

    // reset during ACTIVE, then a normal request
    drive(0, 1, 1, 2'b01, 2'b00, 2'b00);
    tick();
    expect_out("rstact.act", 2'b01, 2'b01, 0, 0, D0);
    tick();
    drive(1, 1, 1, 2'b01, 2'b00, 2'b00);
    tick();
    drive(0, 0, 0, 2'b00, 2'b00, 2'b00);
    expect_out("rstact.post", 2'b00, 2'b00, 0, 0, 32'h0);
    tick();
    drive(0, 1, 1, 2'b10, 2'b00, 2'b00);
    expect_out("rstact.req", 2'b00, 2'b00, 0, 0, 32'h0);
    tick();
    drive(0, 1, 1, 2'b10, 2'b10, 2'b00);
    expect_out("rstact.ack", 2'b10, 2'b10, 1, 0, D1);
    tick();
    drive(0, 0, 0, 2'b00, 2'b00, 2'b00);
    tick();

    // random traffic against the transaction-level model
    mbusy = 0; merr = 0; mg = 0; mwait = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 0) rst = 1'b1;
      else        rst = ($urandom_range(63) == 0);
      m_cyc = ($urandom_range(7) != 0);
      m_stb = ($urandom_range(3) != 0);
      r = $urandom_range(7);
      if (r == 0)      input_select = 2'b00;
      else if (r == 1) input_select = 2'b11;
      else             input_select = 2'(1 << $urandom_range(1));
      s_ack[0] = ($urandom_range(3) == 0);
      s_ack[1] = ($urandom_range(3) == 0);
      s_err[0] = ($urandom_range(15) == 0);
      s_err[1] = ($urandom_range(15) == 0);
      s_dat_r[0] = $urandom; s_dat_r[1] = $urandom;
      m_adr = $urandom; m_dat_w = $urandom; m_sel = 4'($urandom); m_we = 1'($urandom);
      #4;

      e_cyc = 2'b00; e_stb = 2'b00; e_ack = 0; e_err = 0; e_dat = 32'h0;
      if (mbusy) begin
        e_cyc[mg] = m_cyc;
        e_stb[mg] = m_stb;
        e_ack = m_cyc & s_ack[mg];
        e_err = m_cyc & s_err[mg];
        e_dat = s_dat_r[mg];
      end else if (merr) begin
        e_err = 1;
      end

      if (i != 0) begin
        chk("rnd.s_cyc", 32'(s_cyc), 32'(e_cyc));
        chk("rnd.s_stb", 32'(s_stb), 32'(e_stb));
        chk("rnd.ack",   32'(m_ack), 32'(e_ack));
        chk("rnd.err",   32'(m_err), 32'(e_err));
        chk("rnd.dat",   m_dat_r, e_dat);
      end
      chk("rnd.s_adr", s_adr, m_adr);
      chk("rnd.s_dat", s_dat_w, m_dat_w);
      chk("rnd.s_sel", 32'(s_sel), 32'(m_sel));
      chk("rnd.s_we",  32'(s_we), 32'(m_we));

      if (rst) begin
        mbusy = 0; merr = 0; mwait = 0;
      end else if (merr) begin
        merr = 0;
      end else if (mbusy) begin
        if (!m_cyc || s_ack[mg] || s_err[mg]) begin
          mbusy = 0;
        end else if (mwait + 1 == TMO) begin
          mbusy = 0; merr = 1;
        end else begin
          mwait++;
        end
      end else if (m_cyc && m_stb) begin
        if ($countones(input_select) == 1) begin
          mbusy = 1; mwait = 0;
          mg = input_select[1] ? 1 : 0;
        end else begin
          merr = 1;
        end
      end
      @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
